ddr_init_seq: RTL
=================

# ddr_init_seq

Power-up initialization sequencer for the DDR SDRAM controller. After reset it drives the SDRAM command pins through the JEDEC start-up order: CKE low wait, NOP, precharge-all, optional EMRS/DLL reset, two auto-refreshes, and load mode register. It then raises INIT_DONE and hands the command bus to the normal command stages. It is the stage directly upstream of the mode-register-set command.

## Interface
- T_POWERUP, 20000: cycles CKE held low after reset (200 µs at 100 MHz); range 1..65535.
- T_RP, 2: cycles from PRECHARGE issue to the next command; must be ≥2.
- T_RFC, 8: cycles from AUTO REFRESH issue to the next command; must be ≥2.
- T_MRD, 2: cycles from (E)MRS issue to the next command; must be ≥2.
- T_DLL, 200: cycles after the final MRS before INIT_DONE (DLL lock); used only with the macro.
- MODE_WORD, 13'b0000000100001: final MRS ADDR value (CAS latency 2, sequential burst, burst length 2).
- EMODE_WORD, 13'b0: EMRS ADDR value (DLL enable, normal drive).
- CLK  in  1  controller clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CKE  out  1  SDRAM clock enable.
- RAS  out  1  row strobe, active-low.
- CAS  out  1  column strobe, active-low.
- WE  out  1  write enable, active-low.
- BA  out  2  bank address.
- ADDR  out  13  address / mode bus.
- INIT_DONE  out  1  high from sequence completion until the next reset.

## Operation
- Command encoding (RAS,CAS,WE):
  - NOP = 111
  - PRECHARGE = 010 with ADDR[10]=1 (all banks)
  - AUTO REFRESH = 001
  - MRS/EMRS = 000
- BA and ADDR are 0 except during PRECHARGE, MRS (BA=00) and EMRS (BA=01).
- Every command is asserted for exactly one cycle. All other cycles drive NOP.
- States, in order:
  - PWRUP: CKE=0, NOP, for T_POWERUP cycles.
  - CKE_ON: CKE=1, NOP, for 1 cycle.
  - PRE1, then wait T_RP-1.
  - With the macro only: EMRS (EMODE_WORD), wait T_MRD-1; MRS_DLL (MODE_WORD with ADDR[8]=1), wait T_MRD-1; PRE2, wait T_RP-1.
  - AREF1, wait T_RFC-1.
  - AREF2, wait T_RFC-1.
  - MRS (MODE_WORD, ADDR[8]=0), wait T_MRD-1.
  - With the macro only: DLL_WAIT for T_DLL cycles.
  - DONE: terminal state; INIT_DONE=1, CKE=1, NOP held.
- CKE stays 1 from CKE_ON onward.
- A single 16-bit down-counter times every wait. It is loaded on entry to a wait state, and the state advances when the counter reads 0. No other counters are used.
- Reset in any state, including DONE, returns to PWRUP on the next edge and restarts the full sequence.

## Timing
- Reset values: CKE=0, RAS=CAS=WE=1, BA=0, ADDR=0, INIT_DONE=0, state=PWRUP, counter=T_POWERUP-1.
- The edge-to-edge spacing between consecutive command-issue cycles equals the governing parameter exactly (T_RP, T_RFC or T_MRD).
- First PRECHARGE is in cycle T_POWERUP+1 after reset deassertion (cycle 0 = first edge with RST low).
- Without the macro, INIT_DONE rises T_MRD cycles after the MRS issue cycle.
- With the macro, INIT_DONE rises T_MRD+T_DLL cycles after the MRS issue cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DDR_INIT_DLL_RESET_EN
  - Defined: the EMRS, MRS_DLL, PRE2 and DLL_WAIT states are compiled in (full JEDEC DDR sequence).
  - Undefined: these states are absent; the sequence is PWRUP→CKE_ON→PRE1→AREF1→AREF2→MRS→DONE and T_DLL is unused.

## Structure
- Shared package `ddr_pkg`:
  - command encoding constants CMD_NOP, CMD_PRE, CMD_AREF, CMD_MRS (3-bit RAS/CAS/WE)
  - state enum typedef
  - BA_MRS, BA_EMRS constants
  - ADDR_A10 and ADDR_A8 bit indices
- One natural sub-module: `ddr_wait_cnt` (loadable 16-bit down-counter with a zero flag), reusable by later refresh-timer stages.

## Test plan
- Parameters T_POWERUP=10, T_RP=2, T_RFC=8, T_MRD=2, macro undefined. Release reset:
  - CKE=0 for 10 cycles, then 1.
  - PRE (010, ADDR=0x400) at cycle 11.
  - AREF at 13 and 21.
  - MRS with ADDR=0x021, BA=0 at 29.
  - INIT_DONE=1 at 31.
- Same parameters with the macro defined and T_DLL=5:
  - EMRS (BA=01, ADDR=0) at 13.
  - MRS with ADDR=0x121 at 15.
  - PRE at 17.
  - AREF at 19 and 27.
  - MRS 0x021 at 35.
  - INIT_DONE at 42.
- Check every non-command cycle: RAS=CAS=WE=1 and BA=ADDR=0. Each command is exactly one cycle wide.
- Assert RST at cycle 20 (mid AREF wait) for 1 cycle: outputs return to reset values on the next edge, and the full sequence repeats from cycle 0.
- Assert RST while in DONE: INIT_DONE drops to 0 on the next edge and CKE returns to 0.
- Edge case T_POWERUP=1, T_RFC=2: PRE at cycle 2, AREF at 4 and 6, MRS at 8, INIT_DONE at 10.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR controller command path: command encodings,
// init-sequencer states and wait-counter helpers.
package ddr_pkg;

  localparam int CNT_W = 16;

  // {RAS, CAS, WE}, all active-low on the pins
  typedef logic [2:0] cmd_t;
  localparam cmd_t CMD_NOP  = 3'b111;
  localparam cmd_t CMD_PRE  = 3'b010;
  localparam cmd_t CMD_AREF = 3'b001;
  localparam cmd_t CMD_MRS  = 3'b000;

  localparam logic [1:0] BA_MRS  = 2'b00;
  localparam logic [1:0] BA_EMRS = 2'b01;

  localparam int ADDR_A10 = 10;
  localparam int ADDR_A8  = 8;

  typedef enum logic [4:0] {
    ST_PWRUP,
    ST_CKE_ON,
    ST_PRE1,
    ST_PRE1_W,
    ST_EMRS,
    ST_EMRS_W,
    ST_MRS_DLL,
    ST_MRS_DLL_W,
    ST_PRE2,
    ST_PRE2_W,
    ST_AREF1,
    ST_AREF1_W,
    ST_AREF2,
    ST_AREF2_W,
    ST_MRS,
    ST_MRS_W,
    ST_DLL_WAIT,
    ST_DONE
  } init_state_e;

  // Counter preload for a wait lasting `cycles` cycles (advance when it reads 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ddr_init_seq_if.sv
// SDRAM command-pin bundle driven by the init sequencer and consumed downstream.
interface ddr_init_seq_if;
  logic        cke;
  logic        ras;
  logic        cas;
  logic        we;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        init_done;

  modport master (output cke, ras, cas, we, ba, addr, init_done);
  modport slave  (input  cke, ras, cas, we, ba, addr, init_done);
endinterface

// File: rtl/ddr_wait_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero until reloaded.
module ddr_wait_cnt
  import ddr_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up initialization sequencer. Define DDR_INIT_DLL_RESET_EN to
// add the EMRS / DLL-reset MRS / second precharge / DLL-lock wait steps.
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int          T_POWERUP  = 20000,
  parameter int          T_RP       = 2,
  parameter int          T_RFC      = 8,
  parameter int          T_MRD      = 2,
  parameter int          T_DLL      = 200,
  parameter logic [12:0] MODE_WORD  = 13'b0000000100001,
  parameter logic [12:0] EMODE_WORD = 13'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ddr_init_seq_if.master cmd_o
);

  // A8 is the DLL-reset bit and is owned by the sequencer; A0=1 would disable the DLL.
  if (T_POWERUP < 1 || T_POWERUP > 65535 || T_RP < 2 || T_RFC < 2 || T_MRD < 2 ||
      T_DLL < 1 || MODE_WORD[ADDR_A8] || EMODE_WORD[0]) begin : g_param_check
    $error("ddr_init_seq: illegal timing or mode-word parameter");
  end

  // Command states last one cycle, so each following wait runs for T-1 cycles.
  localparam logic [CNT_W-1:0] PWRUP_LOAD = cnt_load(T_POWERUP);
  localparam logic [CNT_W-1:0] RP_LOAD    = cnt_load(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD   = cnt_load(T_RFC - 1);
  localparam logic [CNT_W-1:0] MRD_LOAD   = cnt_load(T_MRD - 1);
`ifdef DDR_INIT_DLL_RESET_EN
  localparam logic [CNT_W-1:0] DLL_LOAD   = cnt_load(T_DLL);
`endif

  init_state_e      state_q, state_d;
  logic             cnt_load_en;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  logic             cke_q, cke_d;
  cmd_t             cmd_q, cmd_d;
  logic [1:0]       ba_q, ba_d;
  logic [12:0]      addr_q, addr_d;
  logic             done_q, done_d;

  ddr_wait_cnt #(
    .RST_VAL(PWRUP_LOAD)
  ) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load_en),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_load_en  = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_PWRUP:   if (cnt_zero) state_d = ST_CKE_ON;
      ST_CKE_ON:  state_d = ST_PRE1;
      ST_PRE1: begin
        state_d      = ST_PRE1_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = RP_LOAD;
      end
      ST_PRE1_W: begin
        if (cnt_zero) begin
`ifdef DDR_INIT_DLL_RESET_EN
          state_d = ST_EMRS;
`else
          state_d = ST_AREF1;
`endif
        end
      end
`ifdef DDR_INIT_DLL_RESET_EN
      ST_EMRS: begin
        state_d      = ST_EMRS_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = MRD_LOAD;
      end
      ST_EMRS_W:  if (cnt_zero) state_d = ST_MRS_DLL;
      ST_MRS_DLL: begin
        state_d      = ST_MRS_DLL_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = MRD_LOAD;
      end
      ST_MRS_DLL_W: if (cnt_zero) state_d = ST_PRE2;
      ST_PRE2: begin
        state_d      = ST_PRE2_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = RP_LOAD;
      end
      ST_PRE2_W:  if (cnt_zero) state_d = ST_AREF1;
`endif
      ST_AREF1: begin
        state_d      = ST_AREF1_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = RFC_LOAD;
      end
      ST_AREF1_W: if (cnt_zero) state_d = ST_AREF2;
      ST_AREF2: begin
        state_d      = ST_AREF2_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = RFC_LOAD;
      end
      ST_AREF2_W: if (cnt_zero) state_d = ST_MRS;
      ST_MRS: begin
        state_d      = ST_MRS_W;
        cnt_load_en  = 1'b1;
        cnt_load_val = MRD_LOAD;
      end
      ST_MRS_W: begin
        if (cnt_zero) begin
`ifdef DDR_INIT_DLL_RESET_EN
          state_d      = ST_DLL_WAIT;
          cnt_load_en  = 1'b1;
          cnt_load_val = DLL_LOAD;
`else
          state_d      = ST_DONE;
`endif
        end
      end
`ifdef DDR_INIT_DLL_RESET_EN
      ST_DLL_WAIT: if (cnt_zero) state_d = ST_DONE;
`endif
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_PWRUP;
    endcase
  end

  // Pins are decoded from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    done_d = 1'b0;
    case (state_d)
      ST_PWRUP: cke_d = 1'b0;
      ST_PRE1, ST_PRE2: begin
        cmd_d            = CMD_PRE;
        addr_d[ADDR_A10] = 1'b1;
      end
      ST_AREF1, ST_AREF2: cmd_d = CMD_AREF;
      ST_MRS: begin
        cmd_d           = CMD_MRS;
        ba_d            = BA_MRS;
        addr_d          = MODE_WORD;
        addr_d[ADDR_A8] = 1'b0;
      end
`ifdef DDR_INIT_DLL_RESET_EN
      ST_EMRS: begin
        cmd_d  = CMD_MRS;
        ba_d   = BA_EMRS;
        addr_d = EMODE_WORD;
      end
      ST_MRS_DLL: begin
        cmd_d           = CMD_MRS;
        ba_d            = BA_MRS;
        addr_d          = MODE_WORD;
        addr_d[ADDR_A8] = 1'b1;
      end
`endif
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_PWRUP;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign cmd_o.cke       = cke_q;
  assign cmd_o.ras       = cmd_q[2];
  assign cmd_o.cas       = cmd_q[1];
  assign cmd_o.we        = cmd_q[0];
  assign cmd_o.ba        = ba_q;
  assign cmd_o.addr      = addr_q;
  assign cmd_o.init_done = done_q;

endmodule
